// File: rtl/dot_acc_pkg.sv
// Shared widths, FSM state type and the carry-save helper for the dot-product stage.
package dot_acc_pkg;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } dot_acc_state_t;

   typedef struct packed {
      logic [PROD_W-1:0] c;
      logic [PROD_W-1:0] s;
   } csa_t;

   // Word-level 3:2 compressor; the carry row is pre-shifted into its column.
   function automatic csa_t csa3(input logic [PROD_W-1:0] x,
                                 input logic [PROD_W-1:0] y,
                                 input logic [PROD_W-1:0] z);
      csa_t r;
      r.s = x ^ y ^ z;
      r.c = ((x & y) | (x & z) | (y & z)) << 1;
      return r;
   endfunction
endpackage

// File: rtl/wallace.sv
// Unsigned 8x8 Wallace-tree multiplier: 8 partial-product rows reduced to 2 by
// four levels of carry-save adders, then one carry-propagate add.
module wallace
   import dot_acc_pkg::*;
(
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic [PROD_W-1:0] p_o
);
   logic [PROD_W-1:0] pp [OP_W];
   csa_t l1a, l1b, l2a, l2b, l3, l4;

   always_comb begin
      for (int i = 0; i < OP_W; i++) begin
         pp[i] = (PROD_W'(a_i) & {PROD_W{b_i[i]}}) << i;
      end
   end

   // 8 -> 6 -> 4 -> 3 -> 2 rows
   assign l1a = csa3(pp[0], pp[1], pp[2]);
   assign l1b = csa3(pp[3], pp[4], pp[5]);
   assign l2a = csa3(l1a.s, l1a.c, l1b.s);
   assign l2b = csa3(l1b.c, pp[6], pp[7]);
   assign l3  = csa3(l2a.s, l2a.c, l2b.s);
   assign l4  = csa3(l3.s, l3.c, l2b.c);

   assign p_o = l4.s + l4.c;
endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot-product accumulator: LEN operand pairs -> one ACC_W-bit sum.
// Build option DOT_ACC_SAT_EN selects saturating accumulation with a sticky out_ovf.
//
// state | meaning
// ACC   | accepting pairs, cnt tracks pairs taken for this vector
// FLUSH | input closed, last products draining through S1/S2 into acc
// DONE  | result presented on out_sum until downstream takes it
module dot_product_acc
   import dot_acc_pkg::*;
#(
   parameter int LEN   = 8,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);
   localparam logic [7:0] CNT_LAST = 8'(LEN - 1);

   dot_acc_state_t    state_q;
   logic [OP_W-1:0]   a_q, b_q;
   logic              v1_q, v2_q;
   logic [PROD_W-1:0] prod_d, prod_q;
   logic [ACC_W-1:0]  acc_d, acc_q;
   logic [7:0]        cnt_q;
   logic              in_ready_q, out_valid_q;
   logic              accept, out_fire;

   assign accept   = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   wallace u_wallace (
      .a_i (a_q),
      .b_i (b_q),
      .p_o (prod_d)
   );

`ifdef DOT_ACC_SAT_EN
   logic [ACC_W:0] sum_full;
   logic           ovf_q;

   assign sum_full = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
   assign acc_d    = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (out_fire) begin
         ovf_q <= 1'b0;
      end else if (v2_q && sum_full[ACC_W]) begin
         ovf_q <= 1'b1;
      end
   end

   assign out_ovf = ovf_q;
`else
   assign acc_d   = acc_q + ACC_W'(prod_q);
   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACC;
         a_q         <= '0;
         b_q         <= '0;
         v1_q        <= 1'b0;
         prod_q      <= '0;
         v2_q        <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         v1_q <= accept;
         if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            prod_q <= prod_d;
         end
         if (v2_q) begin
            acc_q <= acc_d;
         end

         case (state_q)
            ACC: begin
               if (accept) begin
                  if (cnt_q == CNT_LAST) begin
                     state_q    <= FLUSH;
                     in_ready_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            FLUSH: begin
               // v1 is always set on the first FLUSH edge, so this fires on the last product
               if (v2_q && !v1_q) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= ACC;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= ACC;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
endmodule

// File: tb/tb_dot_product_acc.sv
// Randomized bench for dot_product_acc: a transaction-level model of the LEN=8 instance
// checked every cycle, plus literal checks on both instances (LEN=8/ACC_W=24, LEN=2/ACC_W=16).
module tb_dot_product_acc;
   localparam int LEN8 = 8;
   localparam int W8   = 24;
   localparam int W2   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_a = 8'd0, in_b = 8'd0;
   logic out_ready = 1'b0;

   logic iv8, iv2, or8, or2;
   logic rdy8, rdy2, ov8, ov2, ovf8, ovf2;
   logic [W8-1:0] sum8;
   logic [W2-1:0] sum2;

   int nvec = 0;
   int nmis = 0;

   assign iv8 = in_valid & ~sel;
   assign iv2 = in_valid & sel;
   assign or8 = out_ready & ~sel;
   assign or2 = out_ready & sel;

   always #5 clk = ~clk;

   dot_product_acc #(.LEN(LEN8), .ACC_W(W8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .in_a(in_a), .in_b(in_b),
      .out_valid(ov8), .out_ready(or8), .out_sum(sum8), .out_ovf(ovf8));

   dot_product_acc #(.LEN(2), .ACC_W(W2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
      .out_valid(ov2), .out_ready(or2), .out_sum(sum2), .out_ovf(ovf2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Transaction-level model of the LEN=8 instance
   typedef struct {
      longint sum;
      int     cnt;
      int     wt;
      bit     rdy;
      bit     vld;
   } model_t;

   model_t m = '{sum: 0, cnt: 0, wt: 0, rdy: 1'b1, vld: 1'b0};

   function automatic model_t step(input model_t p, input logic iv, input logic ordy,
                                   input logic [7:0] a, input logic [7:0] b);
      model_t n = p;
      if (p.vld && ordy) begin
         n.vld = 1'b0; n.rdy = 1'b1; n.sum = 0; n.cnt = 0;
      end
      if (n.wt > 0) begin
         n.wt--;
         if (n.wt == 0) n.vld = 1'b1;
      end
      if (p.rdy && iv) begin
         n.sum += longint'(a) * longint'(b);
         n.cnt++;
         if (n.cnt == LEN8) begin
            n.rdy = 1'b0;
            n.wt  = 2;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] exp_sum8(input longint s);
`ifdef DOT_ACC_SAT_EN
      return (s >= (64'd1 << W8)) ? 32'((64'd1 << W8) - 1) : 32'(s);
`else
      return 32'(s % (64'd1 << W8));
`endif
   endfunction

   function automatic logic [31:0] exp_ovf8(input longint s);
`ifdef DOT_ACC_SAT_EN
      return (s >= (64'd1 << W8)) ? 32'd1 : 32'd0;
`else
      return 32'(s - s);
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '{sum: 0, cnt: 0, wt: 0, rdy: 1'b1, vld: 1'b0};
      else     m <= step(m, iv8, or8, in_a, in_b);
   end

   always @(negedge clk) begin
      chk("in_ready8", 32'(rdy8), 32'(m.rdy));
      chk("out_valid8", 32'(ov8), 32'(m.vld));
      if (m.vld) begin
         chk("out_sum8", 32'(sum8), exp_sum8(m.sum));
         chk("out_ovf8", 32'(ovf8), exp_ovf8(m.sum));
      end
   end

   function automatic logic cur_ready();
      return sel ? rdy2 : rdy8;
   endfunction
   function automatic logic cur_ovalid();
      return sel ? ov2 : ov8;
   endfunction
   function automatic logic [31:0] cur_sum();
      return sel ? 32'(sum2) : 32'(sum8);
   endfunction
   function automatic logic cur_ovf();
      return sel ? ovf2 : ovf8;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the pair is accepted.
   task automatic push(input logic [7:0] a, input logic [7:0] b, input int bubble_max);
      int gap, n;
      gap = (bubble_max > 0) ? int'($urandom_range(bubble_max, 0)) : 0;
      repeat (gap) begin
         in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1; in_a = a; in_b = b;
      n = 0;
      @(negedge clk);
      while (!cur_ready() && n < 64) begin @(negedge clk); n++; end
      if (!cur_ready()) chk("push_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Waits for a result, holds backpressure for 'hold' cycles while offering ignored
   // inputs, checks against literal expectations (exp < 0 skips), then handshakes.
   task automatic drain(input string nm, input int hold, input longint exp, input logic exp_ovf);
      int n;
      logic [31:0] s0;
      n = 0;
      @(negedge clk);
      while (!cur_ovalid() && n < 64) begin @(negedge clk); n++; end
      if (!cur_ovalid()) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
         @(posedge clk); #1;
         return;
      end
      s0 = cur_sum();
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      repeat (hold) begin
         @(negedge clk);
         chk({nm, "_hold_sum"}, cur_sum(), s0);
         chk({nm, "_hold_ready"}, 32'(cur_ready()), 32'd0);
      end
      if (exp >= 0) begin
         chk({nm, "_sum"}, cur_sum(), 32'(exp));
         chk({nm, "_ovf"}, 32'(cur_ovf()), 32'(exp_ovf));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset held 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(ov8), 32'd0);
      chk("rst_out_sum", 32'(sum8), 32'd0);
      chk("rst_out_ovf", 32'(ovf8), 32'd0);
      chk("rst_in_ready", 32'(rdy8), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      repeat (4) begin @(posedge clk); #1; end

      // a = 1..8, b = 2 back to back -> 72
      for (int i = 1; i <= 8; i++) push(8'(i), 8'd2, 0);
      drain("seq72", 0, 72, 1'b0);

      // a = b = 255 with bubbles, then 5 cycles of backpressure -> 520200
      for (int i = 0; i < 8; i++) push(8'd255, 8'd255, 3);
      drain("max8", 5, 520200, 1'b0);

      // Fresh vector right after the handshake: no carry-over
      for (int i = 0; i < 8; i++) push(8'd3, 8'd3, 0);
      drain("nine8", 0, 72, 1'b0);

      // Random vectors, model-checked
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 8; i++) push(8'($urandom), 8'($urandom), 2);
         drain("rand", int'($urandom_range(3, 0)), -1, 1'b0);
      end

      // LEN=2, ACC_W=16 instance: 2 * 65025 overflows 16 bits
      sel = 1'b1;
      push(8'd255, 8'd255, 0);
      push(8'd255, 8'd255, 0);
`ifdef DOT_ACC_SAT_EN
      drain("w16", 2, 65535, 1'b1);
`else
      drain("w16", 2, 64514, 1'b0);
`endif
      sel = 1'b0;
      @(posedge clk); #1;

      // Async reset after 5 of 8 accepts
      for (int i = 0; i < 5; i++) push(8'd7, 8'd9, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_sum", 32'(sum8), 32'd0);
      chk("arst_out_valid", 32'(ov8), 32'd0);
      chk("arst_in_ready", 32'(rdy8), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) push(8'd1, 8'd1, 0);
      drain("after_rst", 0, 8, 1'b0);

      repeat (3) begin @(posedge clk); #1; end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
